// File: rtl/conv_enc_k3.sv
// rtl/conv_enc_k3.sv - rate-1/2 K=3 convolutional encoder (G0=111, G1=101), valid/ready in and out.
// CONV_TAIL_EN: append two zero tail symbols per frame and return the encoder state to 00.
module conv_enc_k3 #(
  parameter int FRAME_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_sof,
  output logic       out_eof,
  output logic       busy
);

  localparam int CW = $clog2(FRAME_LEN + 2);

`ifdef CONV_TAIL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, TAIL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t        state, state_nxt;
  logic [1:0]    s, s_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          in_tail;
  logic          out_free;
  logic          accept;
  logic          load;
  logic          d;
  logic          last_data;
  logic          eof_nxt;

`ifdef CONV_TAIL_EN
  assign in_tail = (state == TAIL);
`else
  assign in_tail = 1'b0;
`endif

  assign out_free  = !out_valid || out_ready;
  // Gated by rst_n so in_ready reads 0 while reset is held.
  assign in_ready  = rst_n && !in_tail && out_free;
  assign accept    = in_valid && in_ready;
  assign load      = accept || (in_tail && out_free);
  assign d         = in_tail ? 1'b0 : in_bit;
  assign last_data = (cnt == CW'(FRAME_LEN - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    s_nxt     = s;
    eof_nxt   = 1'b0;
    if (load) begin
      cnt_nxt = cnt + CW'(1);
      s_nxt   = {d, s[1]};
      case (state)
        IDLE, DATA: begin
          if (last_data) begin
`ifdef CONV_TAIL_EN
            state_nxt = TAIL;
`else
            // Without a tail the shift register carries over into the next frame.
            state_nxt = IDLE;
            cnt_nxt   = '0;
            eof_nxt   = 1'b1;
`endif
          end else begin
            state_nxt = DATA;
          end
        end
`ifdef CONV_TAIL_EN
        TAIL: begin
          if (cnt == CW'(FRAME_LEN + 1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            s_nxt     = 2'b00;
            eof_nxt   = 1'b1;
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= 2'b00;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      s   <= s_nxt;
      cnt <= cnt_nxt;
      if (load) begin
        out_valid <= 1'b1;
        out_sym   <= {d ^ s[1] ^ s[0], d ^ s[0]};
        out_sof   <= (state == IDLE);
        out_eof   <= eof_nxt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_enc_k3.sv
// tb/tb_conv_enc_k3.sv - directed table-driven bench for conv_enc_k3 with FRAME_LEN=4.
module tb_conv_enc_k3;

  localparam int FL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_bit = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out_sym;
  logic       out_sof;
  logic       out_eof;
  logic       busy;

  always #5 clk = ~clk;

  conv_enc_k3 #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_sym(out_sym), .out_sof(out_sof), .out_eof(out_eof), .busy(busy)
  );

  typedef struct packed {
    logic       tail;
    logic       b;
    logic [1:0] sym;
    logic       sof;
    logic       eof;
  } vec_t;

  vec_t exp_q[$];
  vec_t cap_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stall_cnt = 0;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready)
      cap_q.push_back('{1'b0, 1'b0, out_sym, out_sof, out_eof});

  always @(negedge clk)
    if (rst_n && in_valid && !in_ready && busy) stall_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic add(input logic tl, input logic b, input logic [1:0] sym,
                     input logic sof, input logic eof);
    exp_q.push_back('{tl, b, sym, sof, eof});
  endtask

  task automatic add_frame_a();
    add(0, 1, 2'b11, 1, 0);
    add(0, 0, 2'b10, 0, 0);
    add(0, 1, 2'b00, 0, 0);
`ifdef CONV_TAIL_EN
    add(0, 1, 2'b01, 0, 0);
    add(1, 0, 2'b01, 0, 0);
    add(1, 0, 2'b11, 0, 1);
`else
    add(0, 1, 2'b01, 0, 1);
`endif
  endtask

  // Frame 1,1,0,1 directly after frame A: from s=00 with tail, from s=11 without.
  task automatic add_frame_b();
`ifdef CONV_TAIL_EN
    add(0, 1, 2'b11, 1, 0);
    add(0, 1, 2'b01, 0, 0);
    add(0, 0, 2'b01, 0, 0);
    add(0, 1, 2'b00, 0, 0);
    add(1, 0, 2'b10, 0, 0);
    add(1, 0, 2'b11, 0, 1);
`else
    add(0, 1, 2'b10, 1, 0);
    add(0, 1, 2'b10, 0, 0);
    add(0, 0, 2'b01, 0, 0);
    add(0, 1, 2'b00, 0, 1);
`endif
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    in_bit   = b;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    chk("accept", {31'b0, acc}, 32'd1);
  endtask

  task automatic drive_all();
    foreach (exp_q[i])
      if (!exp_q[i].tail) send_bit(exp_q[i].b);
    in_valid = 1'b0;
  endtask

  task automatic wait_and_compare(input string tag);
    int guard;
    int n;
    guard = 0;
    while (cap_q.size() < exp_q.size() && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk({tag, "_count"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_sym%0d", tag, i), {30'b0, cap_q[i].sym}, {30'b0, exp_q[i].sym});
      chk($sformatf("%s_sof%0d", tag, i), {31'b0, cap_q[i].sof}, {31'b0, exp_q[i].sof});
      chk($sformatf("%s_eof%0d", tag, i), {31'b0, cap_q[i].eof}, {31'b0, exp_q[i].eof});
    end
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic bp_ctrl();
    int guard;
    guard = 0;
    while (cap_q.size() < 1 && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("bp_first_sym_seen", {31'b0, cap_q.size() >= 1}, 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_sym_hold", {30'b0, out_sym}, 32'h2);
      chk("bp_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sym", {30'b0, out_sym}, 32'd0);
    chk("rst_out_sof", {31'b0, out_sof}, 32'd0);
    chk("rst_out_eof", {31'b0, out_eof}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single frame 1,0,1,1
    cap_q.delete();
    exp_q.delete();
    add_frame_a();
    drive_all();
    wait_and_compare("frameA");
    @(negedge clk);
    chk("frameA_busy_after", {31'b0, busy}, 32'd0);

    // Two frames streamed with in_valid held high across the boundary
    do_reset();
    add_frame_a();
    add_frame_b();
    stall_cnt = 0;
    drive_all();
    wait_and_compare("stream");
`ifdef CONV_TAIL_EN
    chk("tail_stall_cycles", stall_cnt, 32'd2);
`else
    chk("tail_stall_cycles", stall_cnt, 32'd0);
`endif

    // Backpressure while the 2nd symbol is presented
    do_reset();
    add_frame_a();
    fork
      drive_all();
      bp_ctrl();
    join
    wait_and_compare("bp");

    // Reset mid-frame then a clean frame
    do_reset();
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cap_q.delete();
    exp_q.delete();
    add_frame_a();
    drive_all();
    wait_and_compare("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
